// File: rtl/apu_event_scheduler.sv
// APU event scheduler: grants upstream banks to the APU read side and tracks
// in-flight events to downstream banks. Optional watchdog: APU_SCHED_TIMEOUT_EN.
module apu_event_scheduler #(
    parameter int EVT_ID_W = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          in_evt_valid,
    input  logic [EVT_ID_W-1:0] in_evt_id0,
    input  logic [EVT_ID_W-1:0] in_evt_id1,
    output logic [1:0]          in_evt_release,
    input  logic [1:0]          out_bank_free,
    output logic                apu_rd_ready,
    input  logic                apu_rd_done,
    input  logic                apu_wr_done,
    output logic                apu_rd_bank,
    output logic                apu_wr_bank,
    output logic [1:0]          out_evt_valid,
    output logic [EVT_ID_W-1:0] out_evt_id,
    output logic                busy,
    output logic [1:0]          err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_REL   = 2'd2;

    logic [1:0]          r_state;
    logic                r_arm;
    logic                r_rr_last;
    logic [1:0]          r_resv;
    logic [EVT_ID_W-1:0] r_fifo_id [2];
    logic [1:0]          r_fifo_bank;
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_cnt;
    logic                r_rd_ready;
    logic                r_rd_bank;
    logic                r_wr_bank;
    logic [1:0]          r_release;
    logic [1:0]          r_evt_valid;
    logic [EVT_ID_W-1:0] r_evt_id;
    logic [1:0]          r_err;

    logic [1:0]          w_avail;
    logic                w_wr_sel;
    logic                w_rd_sel;
    logic                w_grant;
    logic                w_pop;
    logic                w_head_bank;
    logic [1:0]          w_cnt_nxt;
    logic                w_rptr_nxt;
    logic                w_wr_bank_nxt;
    logic [1:0]          w_resv_set;
    logic [1:0]          w_resv_clr;
    logic [1:0]          w_state_nxt;
    logic                w_proto_err;
    logic                w_timeout;

    assign w_avail     = out_bank_free & ~r_resv;
    assign w_wr_sel    = ~w_avail[0];
    assign w_rd_sel    = (in_evt_valid == 2'b11) ? ~r_rr_last : in_evt_valid[1];
    assign w_grant     = r_arm && (r_state == S_IDLE) && (|in_evt_valid)
                         && (|w_avail) && (r_cnt != 2'd2) && !w_timeout;
    assign w_pop       = apu_wr_done && (r_cnt != 2'd0);
    assign w_head_bank = r_fifo_bank[r_rptr];
    assign w_cnt_nxt   = r_cnt + {1'b0, w_grant} - {1'b0, w_pop};
    assign w_rptr_nxt  = r_rptr ^ w_pop;
    assign w_resv_set  = w_grant ? (2'b01 << w_wr_sel) : 2'b00;
    assign w_resv_clr  = w_pop ? (2'b01 << w_head_bank) : 2'b00;
    assign w_proto_err = (apu_rd_done && (r_state != S_GRANT))
                         || (apu_wr_done && (r_cnt == 2'd0));

    // Write-bank select follows the head the FIFO will have after this edge.
    assign w_wr_bank_nxt = (w_cnt_nxt == 2'd0) ? 1'b0 :
                           (w_grant && (r_wptr == w_rptr_nxt)) ? w_wr_sel :
                           r_fifo_bank[w_rptr_nxt];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_GRANT;
            S_GRANT: if (apu_rd_done) w_state_nxt = S_REL;
            S_REL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef APU_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog;
    logic            w_wd_run;
    logic            w_any_done;

    assign w_any_done = apu_rd_done || apu_wr_done;
    assign w_wd_run   = (r_state == S_GRANT) || (r_cnt != 2'd0);
    assign w_timeout  = w_wd_run && !w_any_done
                        && (r_wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (!w_wd_run || w_any_done || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    // A limit below zero is illegal, so this is a constant 0.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_arm        <= 1'b0;
            r_rr_last    <= 1'b1;
            r_resv       <= 2'b00;
            r_fifo_id[0] <= '0;
            r_fifo_id[1] <= '0;
            r_fifo_bank  <= 2'b00;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_cnt        <= 2'd0;
            r_rd_ready   <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_release    <= 2'b00;
            r_evt_valid  <= 2'b00;
            r_evt_id     <= '0;
            r_err        <= 2'b00;
        end else begin
            r_arm    <= 1'b1;
            r_err[0] <= r_err[0] | w_proto_err;
            if (w_timeout) begin
                r_err[1]    <= 1'b1;
                r_state     <= S_IDLE;
                r_resv      <= 2'b00;
                r_wptr      <= 1'b0;
                r_rptr      <= 1'b0;
                r_cnt       <= 2'd0;
                r_rd_ready  <= 1'b0;
                r_wr_bank   <= 1'b0;
                r_release   <= 2'b00;
                r_evt_valid <= 2'b00;
                r_evt_id    <= '0;
            end else begin
                r_state     <= w_state_nxt;
                r_rd_ready  <= (w_state_nxt == S_GRANT);
                r_resv      <= (r_resv & ~w_resv_clr) | w_resv_set;
                r_cnt       <= w_cnt_nxt;
                r_rptr      <= w_rptr_nxt;
                r_wr_bank   <= w_wr_bank_nxt;
                r_release   <= (r_state == S_GRANT && apu_rd_done)
                               ? (2'b01 << r_rd_bank) : 2'b00;
                r_evt_valid <= w_resv_clr;
                r_evt_id    <= w_pop ? r_fifo_id[r_rptr] : '0;
                if (w_grant) begin
                    r_rd_bank           <= w_rd_sel;
                    r_rr_last           <= w_rd_sel;
                    r_fifo_id[r_wptr]   <= w_rd_sel ? in_evt_id1 : in_evt_id0;
                    r_fifo_bank[r_wptr] <= w_wr_sel;
                    r_wptr              <= ~r_wptr;
                end
            end
        end
    end

    assign apu_rd_ready   = r_rd_ready;
    assign apu_rd_bank    = r_rd_bank;
    assign apu_wr_bank    = r_wr_bank;
    assign in_evt_release = r_release;
    assign out_evt_valid  = r_evt_valid;
    assign out_evt_id     = r_evt_id;
    assign busy           = (r_state != S_IDLE) || (r_cnt != 2'd0);
    assign err            = r_err;

endmodule

// File: tb/tb_apu_event_scheduler.sv
// Bench for apu_event_scheduler: directed vector table, hand sequences and
// random stimulus checked against a queue-based transaction model.
module tb_apu_event_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_evt_valid;
    logic [7:0] in_evt_id0;
    logic [7:0] in_evt_id1;
    logic [1:0] in_evt_release;
    logic [1:0] out_bank_free;
    logic       apu_rd_ready;
    logic       apu_rd_done;
    logic       apu_wr_done;
    logic       apu_rd_bank;
    logic       apu_wr_bank;
    logic [1:0] out_evt_valid;
    logic [7:0] out_evt_id;
    logic       busy;
    logic [1:0] err;

    int n_chk  = 0;
    int n_fail = 0;

    apu_event_scheduler #(.EVT_ID_W(8), .TIMEOUT(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_evt_valid   (in_evt_valid),
        .in_evt_id0     (in_evt_id0),
        .in_evt_id1     (in_evt_id1),
        .in_evt_release (in_evt_release),
        .out_bank_free  (out_bank_free),
        .apu_rd_ready   (apu_rd_ready),
        .apu_rd_done    (apu_rd_done),
        .apu_wr_done    (apu_wr_done),
        .apu_rd_bank    (apu_rd_bank),
        .apu_wr_bank    (apu_wr_bank),
        .out_evt_valid  (out_evt_valid),
        .out_evt_id     (out_evt_id),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic [7:0] id;
        logic       bank;
    } ent_t;

    ent_t       q[$];
    bit         m_armed;
    int         m_rd;       // 0 read side free, 1 owned by APU, 2 releasing
    logic       m_rd_bank;
    logic       m_last;
    logic [1:0] m_err;
    logic [1:0] e_rel;
    logic [1:0] e_evt;
    logic [7:0] e_id;

    task automatic model_reset();
        q.delete();
        m_armed   = 1'b0;
        m_rd      = 0;
        m_rd_bank = 1'b0;
        m_last    = 1'b1;
        m_err     = 2'b00;
        e_rel     = 2'b00;
        e_evt     = 2'b00;
        e_id      = 8'h00;
    endtask

    task automatic model_step(input logic [1:0] v, input logic [1:0] f,
                              input logic rd, input logic wr,
                              input logic [7:0] a, input logic [7:0] b);
        logic [1:0] resv;
        logic [1:0] avail;
        logic       g;
        logic       sel;
        logic       wb;
        int         nrd;
        ent_t       e;
        resv = 2'b00;
        foreach (q[i]) resv[q[i].bank] = 1'b1;
        avail = f & ~resv;
        e_rel = 2'b00;
        e_evt = 2'b00;
        e_id  = 8'h00;
        sel   = 1'b0;
        wb    = 1'b0;
        nrd   = (m_rd == 2) ? 0 : m_rd;
        if (rd) begin
            if (m_rd == 1) begin
                nrd = 2;
                e_rel[m_rd_bank] = 1'b1;
            end else begin
                m_err[0] = 1'b1;
            end
        end
        g = (m_rd == 0) && m_armed && (v != 2'b00) && (avail != 2'b00)
            && (q.size() < 2);
        if (g) begin
            sel       = (v == 2'b11) ? ~m_last : v[1];
            wb        = avail[0] ? 1'b0 : 1'b1;
            nrd       = 1;
            m_rd_bank = sel;
            m_last    = sel;
        end
        if (wr) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                e_evt[e.bank] = 1'b1;
                e_id = e.id;
            end else begin
                m_err[0] = 1'b1;
            end
        end
        if (g) q.push_back({(sel ? b : a), wb});
        m_rd    = nrd;
        m_armed = 1'b1;
    endtask

    task automatic cycle(input logic [1:0] v, input logic [1:0] f,
                         input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] b);
        logic [7:0] exp_v;
        in_evt_valid  = v;
        out_bank_free = f;
        apu_rd_done   = rd;
        apu_wr_done   = wr;
        in_evt_id0    = a;
        in_evt_id1    = b;
        @(posedge clk);
        model_step(v, f, rd, wr, a, b);
        @(negedge clk);
        exp_v = {(m_rd == 1), e_rel, e_evt, m_rd_bank,
                 (m_rd != 0 || q.size() != 0)};
        chk("model_ctl",
            32'({apu_rd_ready, in_evt_release, out_evt_valid, apu_rd_bank, busy}),
            32'(exp_v));
        chk("model_err", 32'(err), 32'(m_err));
        if (q.size() != 0) chk("model_wr_bank", 32'(apu_wr_bank), 32'(q[0].bank));
        if (e_evt != 2'b00) chk("model_evt_id", 32'(out_evt_id), 32'(e_id));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] v;
        logic [1:0] f;
        logic       rd;
        logic       wr;
        logic       rdy;
        logic [1:0] rel;
        logic [1:0] evt;
        logic [7:0] id;
        logic       wk;
        logic       wrb;
        logic       rdb;
        logic       bsy;
        logic [1:0] er;
    } vec_t;

    vec_t tbl[18];

    task automatic reset_dut();
        reset         = 1'b1;
        in_evt_valid  = 2'b00;
        out_bank_free = 2'b00;
        apu_rd_done   = 1'b0;
        apu_wr_done   = 1'b0;
        in_evt_id0    = 8'h00;
        in_evt_id1    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[1]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[2]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[3]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[4]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[5]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[6]  = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        tbl[7]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        tbl[8]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        tbl[9]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00};
        tbl[10] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[11] = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[12] = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[13] = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[14] = '{2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[15] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[16] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[17] = '{2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};

        reset = 1'b1;
        in_evt_valid  = 2'b11;
        out_bank_free = 2'b11;
        apu_rd_done   = 1'b1;
        apu_wr_done   = 1'b1;
        in_evt_id0    = 8'h11;
        in_evt_id1    = 8'h22;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({apu_rd_ready, in_evt_release, out_evt_valid, out_evt_id,
                 apu_rd_bank, apu_wr_bank, busy, err}), 32'd0);
        reset_dut();

        for (int i = 0; i < 18; i++) begin
            in_evt_valid  = tbl[i].v;
            out_bank_free = tbl[i].f;
            apu_rd_done   = tbl[i].rd;
            apu_wr_done   = tbl[i].wr;
            in_evt_id0    = 8'h11;
            in_evt_id1    = 8'h22;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i),
                32'({apu_rd_ready, in_evt_release, out_evt_valid, apu_rd_bank, busy, err}),
                32'({tbl[i].rdy, tbl[i].rel, tbl[i].evt, tbl[i].rdb, tbl[i].bsy, tbl[i].er}));
            if (tbl[i].wk) chk($sformatf("vec%0d_wr_bank", i), 32'(apu_wr_bank), 32'(tbl[i].wrb));
            if (tbl[i].evt != 2'b00) chk($sformatf("vec%0d_id", i), 32'(out_evt_id), 32'(tbl[i].id));
        end

        // Reset mid-grant clears outputs without waiting for a clock edge.
        #2 reset = 1'b1;
        #1 chk("async_reset_in_grant",
               32'({apu_rd_ready, in_evt_release, out_evt_valid, out_evt_id,
                    apu_rd_bank, apu_wr_bank, busy, err}), 32'd0);
        reset_dut();

        // Fill both in-flight slots, hold off a third grant, then pop and
        // grant in the same cycle.
        cycle(2'b11, 2'b11, 1'b0, 1'b0, 8'hA1, 8'hB1);
        cycle(2'b11, 2'b11, 1'b0, 1'b0, 8'hA1, 8'hB1);
        cycle(2'b11, 2'b11, 1'b1, 1'b0, 8'hA1, 8'hB1);
        cycle(2'b11, 2'b11, 1'b0, 1'b0, 8'hA2, 8'hB1);
        cycle(2'b11, 2'b11, 1'b0, 1'b0, 8'hA2, 8'hB1);
        cycle(2'b11, 2'b11, 1'b1, 1'b0, 8'hA2, 8'hB1);
        for (int i = 0; i < 4; i++) begin
            cycle(2'b11, 2'b11, 1'b0, 1'b0, 8'hA2, 8'hB2);
            chk("full_no_grant", 32'(apu_rd_ready), 32'd0);
        end
        cycle(2'b11, 2'b11, 1'b0, 1'b1, 8'hA2, 8'hB2);
        cycle(2'b11, 2'b11, 1'b0, 1'b1, 8'hA2, 8'hB2);
        chk("push_pop_id", 32'(out_evt_id), 32'h0000_00B1);
        chk("push_pop_busy", 32'(busy), 32'd1);
        cycle(2'b00, 2'b11, 1'b1, 1'b1, 8'hA2, 8'hB2);
        chk("push_pop_last_id", 32'(out_evt_id), 32'h0000_00A2);
        cycle(2'b00, 2'b11, 1'b0, 1'b0, 8'h00, 8'h00);

        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            cycle(2'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
